// File: rtl/calc_entry_pkg.sv
// Shared codes for the calculator keypad front end: phase, operation, key and
// operand-register command encodings.
package calc_entry_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OBL = 2'd2
    } st_e;

    typedef enum logic [2:0] {
        SL_ADD = 3'd0,
        SL_SUB = 3'd1,
        SL_XOR = 3'd2,
        SL_AND = 3'd3,
        SL_OR  = 3'd4
    } sl_e;

    // Command to one 4-digit operand register.
    typedef enum logic [2:0] {
        SH_NOP  = 3'd0,
        SH_SHL  = 3'd1,
        SH_SHR  = 3'd2,
        SH_CLR  = 3'd3,
        SH_LOAD = 3'd4,
        SH_SET1 = 3'd5
    } sh_op_e;

    localparam int unsigned K_DIG_MAX = 9;
    localparam int unsigned K_ADD     = 10;
    localparam int unsigned K_SUB     = 11;
    localparam int unsigned K_XOR     = 12;
    localparam int unsigned K_AND     = 13;
    localparam int unsigned K_OR      = 14;
    localparam int unsigned K_EQ      = 15;
    localparam int unsigned K_CLR     = 16;
    localparam int unsigned K_BKSP    = 17;

endpackage

// File: rtl/calc_entry_bcd_shift4.sv
// Four-digit BCD operand register with digit count; the caller guarantees
// shifts are only requested when the count allows them.
module bcd_shift4
    import calc_entry_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  sh_op_e      i_op,
    input  logic [3:0]  i_din,
    input  logic [15:0] i_load,
    output logic [15:0] o_num,
    output logic [2:0]  o_cnt
);

    logic [15:0] r_num;
    logic [2:0]  r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_num <= 16'd0;
            r_cnt <= 3'd0;
        end else begin
            case (i_op)
                SH_SHL: begin
                    r_num <= {r_num[11:0], i_din};
                    r_cnt <= r_cnt + 3'd1;
                end
                SH_SHR: begin
                    r_num <= {4'd0, r_num[15:4]};
                    r_cnt <= r_cnt - 3'd1;
                end
                SH_CLR: begin
                    r_num <= 16'd0;
                    r_cnt <= 3'd0;
                end
                SH_LOAD: begin
                    r_num <= i_load;
                    r_cnt <= 3'd4;
                end
                SH_SET1: begin
                    r_num <= {12'd0, i_din};
                    r_cnt <= 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_num = r_num;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/calc_entry.sv
// Keypad front end: turns key strobes into operand digits, phase and operation
// codes for the calculator core, chaining onto the core result when enabled.
module calc_entry
    import calc_entry_pkg::*;
#(
    parameter int KEY_W    = 5,
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    input  logic [15:0]      result,
    output logic [3:0]       A1,
    output logic [3:0]       A2,
    output logic [3:0]       A3,
    output logic [3:0]       A4,
    output logic [3:0]       B1,
    output logic [3:0]       B2,
    output logic [3:0]       B3,
    output logic [3:0]       B4,
    output logic [1:0]       ST,
    output logic [2:0]       ST_L,
    output logic             key_err
);

    st_e         r_st;
    sl_e         r_sl;
    logic        r_err;

    logic [31:0] w_kc;
    logic        w_dig, w_op, w_eq, w_clr, w_bksp, w_ill;
    logic [3:0]  w_din;
    sl_e         w_key_sl;
    sh_op_e      w_opA, w_opB;
    st_e         w_nxt_st;
    sl_e         w_nxt_sl;
    logic        w_nxt_err;
    logic [15:0] w_numA, w_numB;
    logic [2:0]  w_cntA, w_cntB;

    assign w_kc     = 32'(key_code);
    assign w_dig    = (w_kc <= K_DIG_MAX);
    assign w_op     = (w_kc >= K_ADD) && (w_kc <= K_OR);
    assign w_eq     = (w_kc == K_EQ);
    assign w_clr    = (w_kc == K_CLR);
    assign w_bksp   = (w_kc == K_BKSP);
    assign w_ill    = (w_kc > K_BKSP);
    assign w_din    = w_kc[3:0];
    assign w_key_sl = sl_e'(3'(w_kc - K_ADD));

    always_comb begin
        w_opA     = SH_NOP;
        w_opB     = SH_NOP;
        w_nxt_st  = r_st;
        w_nxt_sl  = r_sl;
        w_nxt_err = 1'b0;
        case (r_st)
            S_A, S_B, S_OBL: begin
                if (key_valid) begin
                    if (w_ill) begin
                        w_nxt_err = 1'b1;
                    end else if (w_clr) begin
                        w_opA    = SH_CLR;
                        w_opB    = SH_CLR;
                        w_nxt_st = S_A;
                        w_nxt_sl = SL_ADD;
                    end else if (r_st == S_A) begin
                        if (w_dig) begin
                            if (w_cntA < 3'd4) w_opA = SH_SHL;
                            else               w_nxt_err = 1'b1;
                        end else if (w_bksp) begin
                            if (w_cntA != 3'd0) w_opA = SH_SHR;
                            else                w_nxt_err = 1'b1;
                        end else if (w_op) begin
                            w_nxt_sl = w_key_sl;
                            w_nxt_st = S_B;
                        end else begin
                            w_nxt_err = 1'b1;
                        end
                    end else if (r_st == S_B) begin
                        if (w_dig) begin
                            if (w_cntB < 3'd4) w_opB = SH_SHL;
                            else               w_nxt_err = 1'b1;
                        end else if (w_bksp) begin
                            if (w_cntB != 3'd0) w_opB = SH_SHR;
                            else                w_nxt_err = 1'b1;
                        end else if (w_op) begin
                            // Operator may only be changed before B has digits.
                            if (w_cntB == 3'd0) w_nxt_sl = w_key_sl;
                            else                w_nxt_err = 1'b1;
                        end else begin
                            w_nxt_st = S_OBL;
                        end
                    end else begin
                        if (w_dig) begin
                            w_opA    = SH_SET1;
                            w_opB    = SH_CLR;
                            w_nxt_st = S_A;
                        end else if (w_op && CHAIN_EN) begin
                            w_opA    = SH_LOAD;
                            w_opB    = SH_CLR;
                            w_nxt_sl = w_key_sl;
                            w_nxt_st = S_B;
                        end else begin
                            w_nxt_err = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // Corrupted phase code: recover to the reset state.
                w_opA    = SH_CLR;
                w_opB    = SH_CLR;
                w_nxt_st = S_A;
                w_nxt_sl = SL_ADD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st  <= S_A;
            r_sl  <= SL_ADD;
            r_err <= 1'b0;
        end else begin
            r_st  <= w_nxt_st;
            r_sl  <= w_nxt_sl;
            r_err <= w_nxt_err;
        end
    end

    bcd_shift4 u_opa (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_op   (w_opA),
        .i_din  (w_din),
        .i_load (result),
        .o_num  (w_numA),
        .o_cnt  (w_cntA)
    );

    bcd_shift4 u_opb (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_op   (w_opB),
        .i_din  (w_din),
        .i_load (16'd0),
        .o_num  (w_numB),
        .o_cnt  (w_cntB)
    );

    assign {A4, A3, A2, A1} = w_numA;
    assign {B4, B3, B2, B1} = w_numB;
    assign ST      = r_st;
    assign ST_L    = r_sl;
    assign key_err = r_err;

endmodule

// File: doc/calc_entry.md
Name: calc_entry

Overview:
Keypad-side front end of the calculator. It turns single-cycle key strobes into the operand digit registers A1..A4 and B1..B4, the phase code ST and the operation code ST_L that the calculator core reads. It also reads back the core's 16-bit BCD result so that a new operator key can chain onto it. It sits between the keypad debouncer and the calculator core.

Parameters:
KEY_W, 5, width of key_code
CHAIN_EN, 1, 1 = an operator key pressed in S_OBL loads the result into A; 0 = that operator key is rejected

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
key_valid  in  1  one-cycle strobe: key_code is valid this cycle
key_code  in  KEY_W  0-9 digit, 10 ADD, 11 SUB, 12 XOR, 13 AND, 14 OR, 15 EQ, 16 CLR, 17 BKSP, 18-31 illegal
result  in  16  BCD result from the core, {d3,d2,d1,d0}, d0 in [3:0]
A1,A2,A3,A4  out  4 each  operand A BCD digits; A1 least significant, so numberA = {A4,A3,A2,A1}
B1,B2,B3,B4  out  4 each  operand B BCD digits, same ordering
ST  out  2  phase code
ST_L  out  3  selected operation
key_err  out  1  one-cycle pulse: the last key was rejected

Behaviour:
- All outputs are registered. A key is sampled on the rising clk edge where key_valid=1. Its effect, and any key_err pulse, appears on the following cycle. Every cycle with key_valid=1 counts as a separate key.
- Reset (rst=1 at an edge): A*/B*=0, ST=S_A, ST_L=SL_ADD, cntA=cntB=0, key_err=0. rst overrides a key in the same cycle and aborts entry mid-operand.
- Internal digit counters cntA, cntB cover 0..4.
- State S_A:
  - digit: if cnt<4, shift left (A4<=A3, A3<=A2, A2<=A1, A1<=digit) and cnt+1; if cnt=4, key_err and no change.
  - BKSP: shift right (A1<=A2, A2<=A3, A3<=A4, A4<=0) and cnt-1; if cnt=0, key_err.
  - operator: ST_L<=op, ST<=S_B. A may have 0 digits, in which case A=0.
  - EQ: key_err.
- State S_B:
  - digits and BKSP: same rules as S_A, applied to B.
  - operator with cntB=0: replaces ST_L.
  - operator with cntB>0: key_err.
  - EQ: ST<=S_OBL. B may be 0.
- State S_OBL (core output is valid):
  - digit: clear A, B and counts; A1<=digit, cntA=1, ST<=S_A.
  - operator with CHAIN_EN=1: {A4,A3,A2,A1}<=result, cntA=4, B=0, cntB=0, ST_L<=op, ST<=S_B. result is loaded unchecked, including SUB wrap values.
  - operator with CHAIN_EN=0: key_err.
  - EQ and BKSP: key_err, no change.
- CLR in any state gives the reset state with no key_err.
- Illegal codes 18-31 in any state: key_err, no change.
- ST never takes the value 2'd3; if it is ever seen there, the next edge forces the reset state.
- Digits are always 0-9 by construction.

Decomposition:
- Shared defines.vh holds:
  - ST codes: S_A=2'd0, S_B=2'd1, S_OBL=2'd2.
  - ST_L codes: SL_ADD=3'd0, SL_SUB=3'd1, SL_XOR=3'd2, SL_AND=3'd3, SL_OR=3'd4.
  - Key codes: K_ADD..K_BKSP, plus K_DIG_MAX=9.
- Natural sub-module: bcd_shift4, a 4-digit shift register with shift-left-in, shift-right, clear, parallel load and count. It is instantiated twice, once for A and once for B.

Test Plan:
1. Keys 1,2,3,ADD,4,5,EQ → A={0,1,2,3}, ST_L=0, B={0,0,4,5}, ST=2; key_err never asserted.
2. Keys 9,8,7,6,5 → A=9876, fifth key gives key_err for 1 cycle; BKSP → A=0987; four more BKSP → A=0, the last one gives key_err.
3. Sequence 1,SUB,2,EQ, then drive result=16'h0013, then key OR → A=0013, B=0, ST_L=4, ST=1.
4. Key ADD in S_B with cntB=0, then XOR → ST_L=2, no error; then digit 7 followed by AND → key_err, ST_L stays 2.
5. Key code 20, and EQ in S_A → key_err each time, no state change; CLR mid-B entry → reset values next cycle.
6. rst=1 together with key_valid=1 and key 5 → A=0, ST=0, no key_err.
